// File: rtl/serial_subtractor8_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default sizes.
package serial_subtractor8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

endpackage

// File: rtl/serial_subtractor8_fsubtractor.sv
// Combinational one-bit full-subtractor cell: d = x - y - bin, with borrow-out.
module fsubtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock with start/busy/done.
// Define SERIAL_SUB_OVF_EN to compute the signed overflow flag; otherwise ovf is tied to 0.
module serial_subtractor8
  import serial_subtractor8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             bit_d;
  logic             borrow_d;
  logic             last_bit_s;

  fsubtractor u_fsub (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (borrow_d)
  );

  assign last_bit_s = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;

  // Sign bits are captured at start; ovf is judged against the final (MSB) difference bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
      ovf_q   <= ovf_q;
    end else if ((state_q == ST_RUN) && last_bit_s) begin
      a_msb_q <= a_msb_q;
      b_msb_q <= b_msb_q;
      ovf_q   <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
    end else begin
      a_msb_q <= a_msb_q;
      b_msb_q <= b_msb_q;
      ovf_q   <= ovf_q;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Control FSM, operand/result shift registers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q     <= a;
            sb_q     <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sa_q     <= sa_q >> 1;
          sb_q     <= sb_q >> 1;
          res_q    <= {bit_d, res_q[WIDTH-1:1]};
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_bit_s) begin
            d_q     <= {bit_d, res_q[WIDTH-1:1]};
            bout_q  <= borrow_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule
